// File: rtl/spi_slave_engine_pkg.sv
// Shared constants for the SPI responder: default character length, SPI mode
// encodings ({cpol, cpha}), pin indices and the frame state encoding.
package spi_slave_engine_pkg;

   localparam int SPI_CHAR_LEN = 8;

   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

   localparam int PIN_SCLK = 0;
   localparam int PIN_CS_N = 1;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for an asynchronous pin plus one extra stage that
// yields single-cycle rise/fall strobes on the synchronized level.
module spi_pin_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_pin,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
         r_prev <= RST_VAL;
      end else begin
         r_meta <= i_pin;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_rise = r_sync & ~r_prev;
   assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_slave_engine.sv
// SPI responder shift engine: oversampled SCLK/CS_N/MOSI, CPOL/CPHA edge
// classification, and one-word tx/rx buffers with valid/ready handshakes.
module spi_slave_engine
   import spi_slave_engine_pkg::*;
#(
   parameter int CHAR_LEN = SPI_CHAR_LEN,
   parameter int CNT_W    = 6
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_cpol,
   input  logic                i_cpha,
   input  logic                i_lsb,
   input  logic                i_sclk,
   input  logic                i_cs_n,
   input  logic                i_mosi,
   output logic                o_miso,
   output logic                o_miso_oe,
   input  logic [CHAR_LEN-1:0] i_tx_data,
   input  logic                i_tx_valid,
   output logic                o_tx_ready,
   output logic [CHAR_LEN-1:0] o_rx_data,
   output logic                o_rx_valid,
   input  logic                i_rx_ready,
   output logic                o_overrun,
   output logic                o_underrun,
   output logic                o_frame_err,
   input  logic                i_clr_err
);

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(CHAR_LEN);

   function automatic logic first_bit(input logic [CHAR_LEN-1:0] w, input logic lsb);
      return lsb ? w[0] : w[CHAR_LEN-1];
   endfunction

   function automatic logic [CHAR_LEN-1:0] drop_bit(input logic [CHAR_LEN-1:0] w, input logic lsb);
      return lsb ? (w >> 1) : (w << 1);
   endfunction

   logic [1:0] w_pins;
   logic [1:0] w_rise;
   logic [1:0] w_fall;

   assign w_pins[PIN_SCLK] = i_sclk;
   assign w_pins[PIN_CS_N] = i_cs_n;

   // CS_N idles high, so its synchronizer resets to 1 to avoid a false frame start.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_pin
         spi_pin_sync #(.RST_VAL(gi == PIN_CS_N)) u_sync (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_pin  (w_pins[gi]),
            .o_rise (w_rise[gi]),
            .o_fall (w_fall[gi])
         );
      end
   endgenerate

   logic r_mosi_meta, r_mosi_sync;
   state_t r_state, w_state_next;
   logic r_cpol, r_cpha, r_lsb;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [CHAR_LEN-1:0] r_tx_sh, r_rx_sh, r_tx_buf, r_rx_data;
   logic r_tx_full, r_rx_valid, r_miso, r_miso_oe;
   logic r_overrun, r_underrun, r_frame_err;

   logic w_active, w_lead, w_trail, w_sample, w_shift;
   logic w_start, w_stop, w_done, w_reload, w_cpha_eff, w_lsb_eff;
   logic w_tx_load, w_rx_take, w_udr_set, w_ovr_set, w_ferr_set;
   logic [CHAR_LEN-1:0] w_tx_word;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_fall[PIN_CS_N]) w_state_next = ST_ACTIVE;
         ST_ACTIVE: if (w_rise[PIN_CS_N]) w_state_next = ST_IDLE;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   assign w_active = (r_state == ST_ACTIVE);
   assign w_lead   = r_cpol ? w_fall[PIN_SCLK] : w_rise[PIN_SCLK];
   assign w_trail  = r_cpol ? w_rise[PIN_SCLK] : w_fall[PIN_SCLK];
   assign w_sample = w_active & (r_cpha ? w_trail : w_lead);
   // With cpha=0 a shift edge only advances inside a character; this drops the
   // trailing edge after the last sample, since the reload already drove bit 0.
   assign w_shift  = w_active & (r_cpha ? w_lead : w_trail) & (r_cpha | (r_bit_cnt != '0));
   assign w_start  = (r_state == ST_IDLE) & w_fall[PIN_CS_N];
   assign w_stop   = w_active & w_rise[PIN_CS_N];
   assign w_done   = w_active & (r_bit_cnt == LP_LAST);
   assign w_reload = w_start | w_done;
   assign w_cpha_eff = w_start ? i_cpha : r_cpha;
   assign w_lsb_eff  = w_start ? i_lsb : r_lsb;
   assign w_tx_word  = r_tx_full ? r_tx_buf : '0;
   assign w_tx_load  = i_tx_valid & ~r_tx_full;
   assign w_rx_take  = r_rx_valid & i_rx_ready;
   assign w_udr_set  = w_reload & ~r_tx_full;
   assign w_ovr_set  = w_done & r_rx_valid & ~i_rx_ready;
   assign w_ferr_set = w_stop & (r_bit_cnt != '0) & ~w_done;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mosi_meta <= 1'b0;
         r_mosi_sync <= 1'b0;
         r_cpol      <= 1'b0;
         r_cpha      <= 1'b0;
         r_lsb       <= 1'b0;
         r_bit_cnt   <= '0;
         r_tx_sh     <= '0;
         r_rx_sh     <= '0;
         r_tx_buf    <= '0;
         r_rx_data   <= '0;
         r_tx_full   <= 1'b0;
         r_rx_valid  <= 1'b0;
         r_miso      <= 1'b0;
         r_miso_oe   <= 1'b0;
         r_overrun   <= 1'b0;
         r_underrun  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_mosi_meta <= i_mosi;
         r_mosi_sync <= r_mosi_meta;

         if (w_start) begin
            r_cpol    <= i_cpol;
            r_cpha    <= i_cpha;
            r_lsb     <= i_lsb;
            r_miso_oe <= 1'b1;
            r_bit_cnt <= '0;
         end

         if (w_reload) begin
            if (!w_cpha_eff) begin
               r_miso  <= first_bit(w_tx_word, w_lsb_eff);
               r_tx_sh <= drop_bit(w_tx_word, w_lsb_eff);
            end else begin
               r_tx_sh <= w_tx_word;
            end
         end else if (w_shift) begin
            r_miso  <= first_bit(r_tx_sh, r_lsb);
            r_tx_sh <= drop_bit(r_tx_sh, r_lsb);
         end

         if (w_sample) begin
            r_rx_sh   <= r_lsb ? {r_mosi_sync, r_rx_sh[CHAR_LEN-1:1]}
                               : {r_rx_sh[CHAR_LEN-2:0], r_mosi_sync};
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
         end

         if (w_done) begin
            r_bit_cnt <= '0;
            r_rx_data <= r_rx_sh;
         end

         if (w_stop) begin
            r_miso_oe <= 1'b0;
            r_miso    <= 1'b0;
            r_bit_cnt <= '0;
         end

         if (w_done)         r_rx_valid <= 1'b1;
         else if (w_rx_take) r_rx_valid <= 1'b0;

         r_tx_full <= w_tx_load | (r_tx_full & ~w_reload);
         if (w_tx_load) r_tx_buf <= i_tx_data;

         r_overrun   <= w_ovr_set  | (r_overrun   & ~i_clr_err);
         r_underrun  <= w_udr_set  | (r_underrun  & ~i_clr_err);
         r_frame_err <= w_ferr_set | (r_frame_err & ~i_clr_err);
      end
   end

   assign o_miso      = r_miso;
   assign o_miso_oe   = r_miso_oe;
   assign o_tx_ready  = ~r_tx_full;
   assign o_rx_data   = r_rx_data;
   assign o_rx_valid  = r_rx_valid;
   assign o_overrun   = r_overrun;
   assign o_underrun  = r_underrun;
   assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_slave_engine.sv
// Bench for spi_slave_engine: a bit-level SPI master drives the pins while a
// transaction-level model of the buffers and flags is compared every cycle.
module tb_spi_slave_engine;
   import spi_slave_engine_pkg::*;

   localparam int CL = 8;

   logic clk = 1'b0;
   logic i_rst = 1'b1, i_cpol = 1'b0, i_cpha = 1'b0, i_lsb = 1'b0;
   logic i_sclk = 1'b0, i_cs_n = 1'b1, i_mosi = 1'b0;
   logic [CL-1:0] i_tx_data = '0;
   logic i_tx_valid = 1'b0, i_rx_ready = 1'b0, i_clr_err = 1'b0;
   logic o_miso, o_miso_oe, o_tx_ready, o_rx_valid;
   logic o_overrun, o_underrun, o_frame_err;
   logic [CL-1:0] o_rx_data;

   spi_slave_engine #(.CHAR_LEN(CL), .CNT_W(6)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_cpol(i_cpol), .i_cpha(i_cpha), .i_lsb(i_lsb),
      .i_sclk(i_sclk), .i_cs_n(i_cs_n), .i_mosi(i_mosi),
      .o_miso(o_miso), .o_miso_oe(o_miso_oe),
      .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready),
      .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .i_rx_ready(i_rx_ready),
      .o_overrun(o_overrun), .o_underrun(o_underrun), .o_frame_err(o_frame_err),
      .i_clr_err(i_clr_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_fail = 0;
   int quiet_until = 1000000;
   int miso_at = -1;
   logic [CL-1:0] cap_miso = '0;

   // model state
   logic m_rx_valid, m_ovr, m_udr, m_ferr, m_oe, m_tx_full, m_miso;
   logic [CL-1:0] m_rx_data, m_tx_buf, m_cur;
   int m_nbits;
   logic f_cpol, f_cpha, f_lsb;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_rx_valid = 0; m_ovr = 0; m_udr = 0; m_ferr = 0; m_oe = 0;
      m_tx_full = 0; m_miso = 0; m_rx_data = '0; m_tx_buf = '0; m_cur = '0;
      m_nbits = 0;
   endtask

   // The slave takes the buffered word if there is one, otherwise sends zeros.
   task automatic model_take_tx();
      if (m_tx_full) begin
         m_cur = m_tx_buf;
         m_tx_full = 0;
      end else begin
         m_cur = '0;
         m_udr = 1;
      end
   endtask

   always @(negedge clk) begin
      if (cyc >= quiet_until) begin
         check("rx_valid",  32'(o_rx_valid),  32'(m_rx_valid));
         check("rx_data",   32'(o_rx_data),   32'(m_rx_data));
         check("overrun",   32'(o_overrun),   32'(m_ovr));
         check("underrun",  32'(o_underrun),  32'(m_udr));
         check("frame_err", 32'(o_frame_err), 32'(m_ferr));
         check("miso_oe",   32'(o_miso_oe),   32'(m_oe));
         check("tx_ready",  32'(o_tx_ready),  32'(!m_tx_full));
      end
      if (cyc == miso_at) begin
         check("miso", 32'(o_miso), 32'(m_miso));
         cap_miso = {cap_miso[CL-2:0], o_miso};
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      i_rst = 1; i_cs_n = 1; i_sclk = 0;
      tick(3);
      i_rst = 0;
      model_reset();
      tick(3);
      quiet_until = cyc;
      $display("reset");
   endtask

   task automatic host_tx(input logic [CL-1:0] d);
      i_tx_valid = 1; i_tx_data = d;
      quiet_until = cyc + 3;
      m_tx_full = 1; m_tx_buf = d;
      tick(1);
      i_tx_valid = 0;
      check("tx_ready_drop", 32'(o_tx_ready), 32'd0);
      tick(2);
      $display("host tx load 0x%02h", d);
   endtask

   task automatic host_read();
      check("rx_valid_before_read", 32'(o_rx_valid), 32'd1);
      i_rx_ready = 1;
      quiet_until = cyc + 3;
      m_rx_valid = 0;
      tick(1);
      i_rx_ready = 0;
      check("rx_valid_drop", 32'(o_rx_valid), 32'd0);
      tick(2);
      $display("host rx read 0x%02h", o_rx_data);
   endtask

   task automatic clr_err();
      i_clr_err = 1;
      quiet_until = cyc + 3;
      m_ovr = 0; m_udr = 0; m_ferr = 0;
      tick(1);
      i_clr_err = 0;
      tick(2);
      $display("clear errors");
   endtask

   task automatic frame_begin(input logic [1:0] mode, input logic lsb);
      f_cpol = mode[1]; f_cpha = mode[0]; f_lsb = lsb;
      i_cpol = f_cpol; i_cpha = f_cpha; i_lsb = lsb; i_sclk = f_cpol;
      tick(4);
      quiet_until = cyc + 6;
      i_cs_n = 0;
      model_take_tx();
      m_oe = 1; m_nbits = 0;
      tick(8);
      $display("frame start cpol=%0d cpha=%0d lsb=%0d", f_cpol, f_cpha, lsb);
   endtask

   // Master side: each bit is 8 i_clk cycles, MISO checked just before the sample edge.
   task automatic send_bits(input logic [CL-1:0] w, input int nbits);
      int idx;
      for (int b = 0; b < nbits; b++) begin
         idx = f_lsb ? b : CL - 1 - b;
         if (f_cpha) i_sclk = ~f_cpol;
         i_mosi = w[idx];
         tick(3);
         m_miso = m_cur[idx];
         miso_at = cyc + 1;
         tick(1);
         i_sclk = f_cpha ? f_cpol : ~f_cpol;
         m_nbits++;
         if (m_nbits == CL) begin
            quiet_until = cyc + 6;
            m_rx_data = w;
            if (m_rx_valid) m_ovr = 1;
            m_rx_valid = 1;
            model_take_tx();
            m_nbits = 0;
         end
         tick(4);
         if (!f_cpha) i_sclk = f_cpol;
      end
      $display("master sent 0x%02h (%0d bits), miso captured 0x%02h", w, nbits, cap_miso);
   endtask

   task automatic frame_end();
      tick(4);
      quiet_until = cyc + 6;
      i_cs_n = 1;
      if (m_nbits != 0) m_ferr = 1;
      m_oe = 0; m_nbits = 0;
      tick(4);
      check("oe_off_within_4", 32'(o_miso_oe), 32'd0);
      tick(4);
      $display("frame end");
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] modes [3];
      modes[0] = SPI_MODE1; modes[1] = SPI_MODE2; modes[2] = SPI_MODE3;
      model_reset();
      f_cpol = 0; f_cpha = 0; f_lsb = 0;
      do_reset();
      check("reset_tx_ready",  32'(o_tx_ready),  32'd1);
      check("reset_rx_valid",  32'(o_rx_valid),  32'd0);
      check("reset_rx_data",   32'(o_rx_data),   32'd0);
      check("reset_miso",      32'(o_miso),      32'd0);
      check("reset_miso_oe",   32'(o_miso_oe),   32'd0);
      check("reset_flags",     32'({o_overrun, o_underrun, o_frame_err}), 32'd0);

      // mode 0, MSB first
      host_tx(8'hA5);
      frame_begin(SPI_MODE0, 1'b0);
      host_tx(8'h00);
      send_bits(8'h3C, CL);
      check("t1_miso_seq", 32'(cap_miso), 32'hA5);
      frame_end();
      check("t1_rx_data", 32'(o_rx_data), 32'h3C);
      host_read();

      // SCLK wiggles while CS is high must do nothing
      for (int k = 0; k < 4; k++) begin i_sclk = ~i_sclk; tick(4); end
      i_sclk = 0; tick(4);

      // back-to-back characters in one frame
      host_tx(8'hC3);
      frame_begin(SPI_MODE0, 1'b0);
      host_tx(8'h5A);
      send_bits(8'h11, CL);
      check("b2b_miso_1", 32'(cap_miso), 32'hC3);
      check("b2b_rx_1", 32'(o_rx_data), 32'h11);
      host_read();
      host_tx(8'h00);
      send_bits(8'h22, CL);
      check("b2b_miso_2", 32'(cap_miso), 32'h5A);
      check("b2b_rx_2", 32'(o_rx_data), 32'h22);
      host_read();
      frame_end();
      check("b2b_no_flags", 32'({o_overrun, o_underrun, o_frame_err}), 32'd0);

      // overrun: two words with no read
      host_tx(8'hF0);
      frame_begin(SPI_MODE0, 1'b0);
      host_tx(8'h0F);
      send_bits(8'hA1, CL);
      host_tx(8'h00);
      send_bits(8'hB2, CL);
      frame_end();
      check("ovr_flag", 32'(o_overrun), 32'd1);
      check("ovr_rx_data", 32'(o_rx_data), 32'hB2);

      // CS raised after 5 bits
      host_tx(8'h33);
      frame_begin(SPI_MODE0, 1'b0);
      send_bits(8'hC8, 5);
      frame_end();
      check("ferr_flag", 32'(o_frame_err), 32'd1);
      check("ferr_rx_valid_kept", 32'(o_rx_valid), 32'd1);
      check("ferr_rx_data_kept", 32'(o_rx_data), 32'hB2);
      clr_err();
      check("clr_overrun", 32'(o_overrun), 32'd0);
      check("clr_frame_err", 32'(o_frame_err), 32'd0);
      host_read();

      // modes 1..3, LSB first
      for (int m = 0; m < 3; m++) begin
         host_tx(8'h81);
         frame_begin(modes[m], 1'b1);
         host_tx(8'h00);
         send_bits(8'h7E, CL);
         check("mode_miso_seq", 32'(cap_miso), 32'h81);
         frame_end();
         check("mode_rx_data", 32'(o_rx_data), 32'h7E);
         check("mode_oe_idle", 32'(o_miso_oe), 32'd0);
         host_read();
      end

      // frame started with the tx buffer empty
      frame_begin(SPI_MODE0, 1'b0);
      send_bits(8'h96, CL);
      check("udr_miso_zero", 32'(cap_miso), 32'h00);
      frame_end();
      check("udr_flag", 32'(o_underrun), 32'd1);
      check("udr_rx_data", 32'(o_rx_data), 32'h96);
      host_read();
      clr_err();

      // reset in the middle of a character
      host_tx(8'h55);
      frame_begin(SPI_MODE0, 1'b0);
      send_bits(8'hAA, 3);
      quiet_until = cyc + 1000;
      i_rst = 1;
      tick(1);
      check("rst_mid_miso",     32'(o_miso),      32'd0);
      check("rst_mid_oe",       32'(o_miso_oe),   32'd0);
      check("rst_mid_tx_ready", 32'(o_tx_ready),  32'd1);
      check("rst_mid_rx_valid", 32'(o_rx_valid),  32'd0);
      check("rst_mid_rx_data",  32'(o_rx_data),   32'd0);
      check("rst_mid_flags",    32'({o_overrun, o_underrun, o_frame_err}), 32'd0);
      i_cs_n = 1; i_sclk = 0;
      tick(4);
      i_rst = 0;
      model_reset();
      tick(4);
      quiet_until = cyc;
      $display("reset mid-frame");
      tick(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
